mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency unified memory between the pipeline's instruction-fetch port (IF) and data-memory port (DM).
- Sequences each access as request -> memory handshake -> one-cycle response.
- Arbitrates simultaneous requests with DM priority and an anti-starvation override for IF.
- Sits between the pipelined CPU (PC/IF stage and MEM stage) and the backing memory; the CPU stalls its stage while `*_req_i` is high and `*_ready_o` is low.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_fairness.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// State codes, owner encoding and default widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF      = 32;
  localparam int DATA_W_DEF      = 32;
  localparam int STARVE_MAX_DEF  = 4;
  localparam int TIMEOUT_CYC_DEF = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_fairness.sv
// Grant select with DM priority and an IF anti-starvation override.
// starve_cnt counts DM grants made while IF waits (STARVE_MAX >= 1).
module mem_arb_fairness
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic if_req_i,
  input  logic dm_req_i,
  input  logic grant_i,
  output logic grant_if_o
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] MAXV = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt_q;
  logic [CW-1:0] starve_cnt_d;
  logic          starved;

  assign starved    = (starve_cnt_q == MAXV);
  assign grant_if_o = if_req_i & (~dm_req_i | starved);

  // Saturating count of DM wins over a waiting IF; any other grant clears it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_i) begin
      if (grant_if_o || !if_req_i) begin
        starve_cnt_d = '0;
      end else if (!starved) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) starve_cnt_q <= '0;
    else       starve_cnt_q <= starve_cnt_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// IF/DM arbiter onto one variable-latency memory: IDLE -> BUSY -> RESP.
// Optional ack watchdog: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int STARVE_MAX  = STARVE_MAX_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ready_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ready_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  state_t            state_q,    state_d;
  owner_e            owner_q,    owner_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic              we_q,       we_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic grant;
  logic grant_if;
  logic busy;
  logic resp;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_q,     err_d;
`endif

  assign grant = (state_q == ST_IDLE) & (if_req_i | dm_req_i);
  assign busy  = (state_q == ST_BUSY);
  assign resp  = (state_q == ST_RESP);

  mem_arb_fairness #(
    .STARVE_MAX (STARVE_MAX)
  ) u_fair (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .if_req_i   (if_req_i),
    .dm_req_i   (dm_req_i),
    .grant_i    (grant),
    .grant_if_o (grant_if)
  );

  // Next-state: latch the winner in IDLE, wait for ack in BUSY, one RESP cycle.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    err_d      = err_q;
    tmo_cnt_d  = busy ? tmo_cnt_q + 1'b1 : '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          owner_d = grant_if ? OWN_IF : OWN_DM;
          addr_d  = grant_if ? if_addr_i : dm_addr_i;
          we_d    = grant_if ? 1'b0 : dm_we_i;
          wdata_d = grant_if ? '0 : dm_wdata_i;
          state_d = ST_BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      ST_BUSY: begin
        if (mem_ack_i) begin
          if (owner_q == OWN_IF) if_rdata_d = we_q ? '0 : mem_rdata_i;
          else                   dm_rdata_d = we_q ? '0 : mem_rdata_i;
          state_d = ST_RESP;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TLAST) begin
          if (owner_q == OWN_IF) if_rdata_d = '0;
          else                   dm_rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched request registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign if_ready_o  = resp & (owner_q == OWN_IF);
  assign dm_ready_o  = resp & (owner_q == OWN_DM);
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_req_o   = busy;
  assign mem_we_o    = busy & we_q;
  assign mem_addr_o  = busy ? addr_q : '0;
  assign mem_wdata_o = busy ? wdata_q : '0;

`ifdef MEM_ARB_TIMEOUT_EN
  assign err_o = resp & err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Inputs change and outputs are checked on the falling edge.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ready_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_ready_o;
  logic [31:0] dm_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        err_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_ready_o  (if_ready_o),
    .if_rdata_o  (if_rdata_o),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_ready_o  (dm_ready_o),
    .dm_rdata_o  (dm_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .err_o       (err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"},
        {32'd0, if_ready_o, dm_ready_o, mem_req_o, mem_we_o, err_o},
        64'd0);
    chk({tag, "_data"}, {if_rdata_o, dm_rdata_o}, 64'd0);
    chk({tag, "_mem"}, {mem_addr_o, mem_wdata_o}, 64'd0);
  endtask

  initial begin
    rst_i       = 1'b1;
    if_req_i    = 1'b0;
    if_addr_i   = '0;
    dm_req_i    = 1'b0;
    dm_we_i     = 1'b0;
    dm_addr_i   = '0;
    dm_wdata_i  = '0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    step();
    step();
    chk_all_zero("reset");
    chk("reset_state", 64'(dut.state_q), 64'd0);
    rst_i = 1'b0;

    // Single IF read, ack in first BUSY cycle
    if_req_i  = 1'b1;
    if_addr_i = 32'h40;
    step();
    chk("rd_mem_req", 64'(mem_req_o), 64'd1);
    chk("rd_mem_addr", 64'(mem_addr_o), 64'h40);
    chk("rd_mem_we", 64'(mem_we_o), 64'd0);
    chk("rd_no_ready", 64'(if_ready_o), 64'd0);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hDEADBEEF;
    step();
    chk("rd_if_ready", 64'(if_ready_o), 64'd1);
    chk("rd_if_rdata", 64'(if_rdata_o), 64'hDEADBEEF);
    chk("rd_dm_ready", 64'(dm_ready_o), 64'd0);
    chk("rd_resp_req", 64'(mem_req_o), 64'd0);
    mem_ack_i = 1'b0;
    if_req_i  = 1'b0;
    step();
    chk("rd_pulse_end", 64'(if_ready_o), 64'd0);
    chk("rd_hold", 64'(if_rdata_o), 64'hDEADBEEF);

    // Stray ack in IDLE is ignored
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h1234;
    step();
    mem_ack_i = 1'b0;
    chk("stray_ack", {62'd0, if_ready_o, dm_ready_o}, 64'd0);
    chk("stray_state", 64'(dut.state_q), 64'd0);
    step();
    chk("stray_ready", {62'd0, if_ready_o, dm_ready_o}, 64'd0);

    // Simultaneous: DM first, then IF at T+3, ready at T+5
    if_req_i  = 1'b1;
    if_addr_i = 32'h100;
    dm_req_i  = 1'b1;
    dm_we_i   = 1'b0;
    dm_addr_i = 32'h200;
    step();
    chk("sim_dm_first", 64'(mem_addr_o), 64'h200);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h1111;
    step();
    chk("sim_dm_ready", {62'd0, dm_ready_o, if_ready_o}, 64'd2);
    chk("sim_dm_rdata", 64'(dm_rdata_o), 64'h1111);
    mem_ack_i = 1'b0;
    dm_req_i  = 1'b0;
    step();
    chk("sim_idle_gap", 64'(mem_req_o), 64'd0);
    step();
    chk("sim_if_busy", {31'd0, mem_req_o, mem_addr_o}, {31'd0, 1'b1, 32'h100});
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h2222;
    step();
    chk("sim_if_ready", {62'd0, if_ready_o, dm_ready_o}, 64'd2);
    chk("sim_if_rdata", 64'(if_rdata_o), 64'h2222);
    chk("sim_dm_hold", 64'(dm_rdata_o), 64'h1111);
    mem_ack_i = 1'b0;
    if_req_i  = 1'b0;
    step();

    // Starvation: four DM grants, then IF forced through
    if_req_i  = 1'b1;
    if_addr_i = 32'h300;
    dm_req_i  = 1'b1;
    dm_addr_i = 32'h400;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("stv_dm_grant%0d", i), 64'(mem_addr_o), 64'h400);
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'hA0 + 32'(i);
      step();
      mem_ack_i = 1'b0;
      chk($sformatf("stv_dm_ready%0d", i), 64'(dm_ready_o), 64'd1);
      step();
    end
    chk("stv_cnt_max", 64'(dut.u_fair.starve_cnt_q), 64'd4);
    chk("stv_dm_last", 64'(dm_rdata_o), 64'hA3);
    step();
    chk("stv_if_grant", 64'(mem_addr_o), 64'h300);
    chk("stv_cnt_clr", 64'(dut.u_fair.starve_cnt_q), 64'd0);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hBEEF;
    step();
    chk("stv_if_ready", {62'd0, if_ready_o, dm_ready_o}, 64'd2);
    mem_ack_i = 1'b0;
    if_req_i  = 1'b0;
    dm_req_i  = 1'b0;
    step();

    // DM write, ack on the third BUSY cycle; late input change ignored
    dm_req_i   = 1'b1;
    dm_we_i    = 1'b1;
    dm_addr_i  = 32'h8;
    dm_wdata_i = 32'h55AA;
    step();
    dm_wdata_i = 32'hFFFF;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("wr_busy%0d", i),
          {30'd0, mem_req_o, mem_we_o, mem_wdata_o},
          {30'd0, 1'b1, 1'b1, 32'h55AA});
      chk($sformatf("wr_addr%0d", i), 64'(mem_addr_o), 64'h8);
      chk($sformatf("wr_noready%0d", i), 64'(dm_ready_o), 64'd0);
      if (i == 2) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hBAD;
      end
      step();
    end
    mem_ack_i = 1'b0;
    chk("wr_ready", 64'(dm_ready_o), 64'd1);
    chk("wr_rdata0", 64'(dm_rdata_o), 64'd0);
    chk("wr_err", 64'(err_o), 64'd0);
    dm_req_i = 1'b0;
    dm_we_i  = 1'b0;
    step();

    // Reset while waiting in BUSY, then a late ack
    if_req_i  = 1'b1;
    if_addr_i = 32'h500;
    step();
    chk("rst_busy", 64'(mem_req_o), 64'd1);
    rst_i = 1'b1;
    step();
    chk_all_zero("rst_mid");
    rst_i       = 1'b0;
    if_req_i    = 1'b0;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hCAFE;
    step();
    mem_ack_i = 1'b0;
    chk("rst_late_ack", 64'(dut.state_q), 64'd0);
    chk_all_zero("rst_after");
    step();
    chk_all_zero("rst_settle");

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog: no ack for 16 BUSY cycles
    dm_req_i  = 1'b1;
    dm_we_i   = 1'b0;
    dm_addr_i = 32'h600;
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("tmo_busy%0d", i), 64'(mem_req_o), 64'd1);
    end
    step();
    chk("tmo_ready_err", {61'd0, dm_ready_o, err_o, mem_req_o}, 64'd6);
    chk("tmo_rdata", 64'(dm_rdata_o), 64'd0);
    dm_req_i = 1'b0;
    step();
    chk("tmo_err_end", 64'(err_o), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
